// File: rtl/memoredf_sel_pkg.sv
// memoredf_sel_pkg: shared node type, tree depth and winner rule for the argmax selector
package memoredf_sel_pkg;
  localparam int CMP_W = 64;
  typedef struct packed {
    logic        valid;
    logic [15:0] value;
    logic [3:0]  dis;
    logic [2:0]  index;
  } sel_node_t;
  function automatic int levels(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic lt(input logic [CMP_W-1:0] x, input logic [CMP_W-1:0] y, input int vw, input logic wrap);
    logic [CMP_W-1:0] half, d;
    half = 64'd1 << (vw - 1);
    d = (x - y) & ((half << 1) - 64'd1);
    return wrap ? ((d & half) != '0 && d != half) : (x < y);
  endfunction
  function automatic logic better(input logic av, input logic bv, input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b,
                                  input int vw, input logic mode_min, input logic wrap);
    return !bv ? 1'b0 : !av ? 1'b1 : mode_min ? lt(b, a, vw, wrap) : lt(a, b, vw, wrap);
  endfunction
endpackage

// File: rtl/sel_node.sv
// sel_node: two-input selector, higher-index input wins only when strictly better
module sel_node
  import memoredf_sel_pkg::*;
#(
  parameter int VW       = 16,
  parameter int DW       = 4,
  parameter int IW       = 3,
  parameter bit MODE_MIN = 1,
  parameter bit WRAP     = 1
) (
  input  logic [VW+DW+IW:0] a,
  input  logic [VW+DW+IW:0] b,
  output logic [VW+DW+IW:0] y
);
  localparam int W = 1 + VW + DW + IW;
  logic pick_b;
  // ties and invalid b fall back to the lower-index input a
  always_comb pick_b = better(a[W-1], b[W-1], CMP_W'(a[W-2 -: VW]), CMP_W'(b[W-2 -: VW]), VW, MODE_MIN, WRAP);
  assign y = pick_b ? b : a;
endmodule

// File: rtl/pipelined_argmax_selector.sv
// pipelined_argmax_selector: registered binary tree picking the best valid channel
module pipelined_argmax_selector
  import memoredf_sel_pkg::*;
#(
  parameter int N_CHANNELS   = 8,
  parameter int VALUE_WIDTH  = 16,
  parameter int DIS_WIDTH    = 4,
  parameter bit MODE_MIN     = 1,
  parameter bit WRAP_COMPARE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CHANNELS-1:0]             in_valid,
  input  logic [N_CHANNELS*VALUE_WIDTH-1:0] in_value,
  input  logic [N_CHANNELS*DIS_WIDTH-1:0]   in_dis,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [VALUE_WIDTH-1:0]            out_value,
  output logic [DIS_WIDTH-1:0]              out_dis,
  output logic [levels(N_CHANNELS)-1:0]     out_index,
  input  logic                              out_ready
);
  localparam int IW = levels(N_CHANNELS);
  localparam int P  = 1 << IW;
  typedef struct packed {
    logic                   valid;
    logic [VALUE_WIDTH-1:0] value;
    logic [DIS_WIDTH-1:0]   dis;
    logic [IW-1:0]          index;
  } node_t;
  node_t leaf [0:P-1];
  node_t w [1:P-1];
  node_t q [1:P-1];
  logic adv;
  assign adv       = out_ready | ~q[1].valid;
  assign in_ready  = adv;
  assign out_valid = q[1].valid;
  assign out_value = q[1].value;
  assign out_dis   = q[1].dis;
  assign out_index = q[1].index;
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N_CHANNELS) begin : g_in
      assign leaf[i] = {in_valid[i], in_value[i*VALUE_WIDTH +: VALUE_WIDTH], in_dis[i*DIS_WIDTH +: DIS_WIDTH], IW'(i)};
    end else begin : g_pad
      assign leaf[i] = {1'b0, VALUE_WIDTH'(0), DIS_WIDTH'(0), IW'(i)};
    end
  end
  for (genvar k = 1; k < P; k++) begin : g_node
    node_t a, b;
    if (2 * k >= P) begin : g_bottom
      assign a = leaf[2*k-P];
      assign b = leaf[2*k+1-P];
    end else begin : g_inner
      assign a = q[2*k];
      assign b = q[2*k+1];
    end
    sel_node #(
      .VW(VALUE_WIDTH), .DW(DIS_WIDTH), .IW(IW), .MODE_MIN(MODE_MIN), .WRAP(WRAP_COMPARE)
    ) u_sel (
      .a(a), .b(b), .y(w[k])
    );
  end
  // every tree level advances in lockstep whenever the root may move on
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '{default: '0};
    else if (adv) q <= w;
endmodule
